fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Feeds the decode stage's InstrD and PC+4 inputs.
- Instruction memory is a read-only word view of the packed program bus i_datain (word 0 at the MSBs).
- Owns the PC: sequential advance, stall, jump/branch redirect and IF/ID flush.

Parameters:
- NUM_WORDS, 10, number of 32-bit instruction words carried on i_datain.
- NOP_WORD, 32'h0000_0000, word injected on flush or out-of-range fetch (sll $0,$0,0).

Ports:
- clock  input  1  stage clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_datain  input  32*NUM_WORDS  packed program; word k = i_datain[32*(NUM_WORDS-k)-1 -: 32].
- stall_f  input  1  hazard unit: hold PC.
- stall_d  input  1  hazard unit: hold IF/ID register.
- jump_d  input  1  decode resolved j/jal this cycle.
- jump_target_d  input  32  jump target byte address.
- branch_taken_e  input  1  execute resolved a taken beq/bne.
- branch_target_e  input  32  branch target byte address.
- PC  output  32  current fetch address (registered).
- InstrD  output  32  IF/ID instruction.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction.
- end_of_program  output  1  PC word index >= NUM_WORDS (combinational from PC).

Behaviour:
- Reset (reset_n=0, asynchronous): PC=0, InstrD=NOP_WORD, PCPlus4D=0, ValidD=0. Outputs hold while reset_n=0; first fetch on the first rising edge after release.
- Fetch read is combinational: index = PC[31:2]. If index < NUM_WORDS, fetched = word[index], else fetched = NOP_WORD and fetch_valid=0. PC[1:0] is ignored.
- Next-PC priority, highest first:
  1. branch_taken_e -> branch_target_e
  2. jump_d -> jump_target_d
  3. stall_f -> PC (hold)
  4. otherwise -> PC+4
- Redirects override stall_f.
- PC+4 wraps modulo 2^32. No delay slot.
- IF/ID update priority:
  1. branch_taken_e: flush. InstrD=NOP_WORD, ValidD=0, PCPlus4D=0. Kills the wrong-path instructions in IF and ID.
  2. jump_d: flush, same values. Kills the sequential fetch after the jump.
  3. stall_d: hold all three registers.
  4. otherwise: InstrD=fetched, PCPlus4D=PC+4, ValidD=fetch_valid.
- Simultaneous branch_taken_e and jump_d: the branch wins (older instruction); the jump is discarded.
- Out-of-range PC with no redirect: PC keeps advancing by 4, and IF/ID receives NOP_WORD with ValidD=0.
- Latency: an instruction at address A appears on InstrD one edge after PC==A, given no stall/flush.
- i_datain is treated as static during execution. Changes take effect on the next combinational read; there is no re-sampling logic.
- reset_n asserted mid-program: immediate return to reset values regardless of stall/redirect inputs.

Test Plan:
- Reset, then 3 free-running edges with word0=0x20010001, word1=0x0C000007, word2=0x20030002 -> after edge1 InstrD=0x20010001, PCPlus4D=4; after edge2 InstrD=0x0C000007, PCPlus4D=8; PC=0x0C after edge3.
- Raise jump_d=1, jump_target_d=0x1C for one cycle while PC=0x08 -> next edge PC=0x1C, InstrD=0, ValidD=0; following edge InstrD=word7, PCPlus4D=0x20.
- stall_f=stall_d=1 for 2 cycles at PC=0x10 -> PC stays 0x10, InstrD/PCPlus4D unchanged; on release PC=0x14 and InstrD=word4.
- branch_taken_e=1, branch_target_e=0x18 together with jump_d=1, jump_target_d=0x04, and stall_f=1 -> PC=0x18, IF/ID flushed (ValidD=0).
- Run until PC=0x28 (NUM_WORDS=10) -> end_of_program=1; next InstrD=0, ValidD=0; PC continues to 0x2C.
- Pull reset_n low asynchronously mid-cycle at PC=0x14 -> PC=0, InstrD=0, ValidD=0 immediately, before any clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, reads the packed program bus
// combinationally and loads the IF/ID register with redirect flush and stall hold.
module fetch_stage #(
  parameter int          NUM_WORDS = 10,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [32*NUM_WORDS-1:0]   i_datain,
  input  logic                      stall_f,
  input  logic                      stall_d,
  input  logic                      jump_d,
  input  logic [31:0]               jump_target_d,
  input  logic                      branch_taken_e,
  input  logic [31:0]               branch_target_e,
  output logic [31:0]               PC,
  output logic [31:0]               InstrD,
  output logic [31:0]               PCPlus4D,
  output logic                      ValidD,
  output logic                      end_of_program
);

  logic [29:0] index_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] fetched_s;
  logic        fetch_valid_s;
  logic [31:0] pc_next_s;
  logic        flush_s;

  assign index_s        = PC[31:2];
  assign pc_plus4_s     = PC + 32'd4;
  assign end_of_program = (index_s >= 30'(NUM_WORDS));
  // Branch resolves in EX, so it is the older instruction and outranks a jump in ID.
  assign flush_s        = branch_taken_e | jump_d;

  // Instruction read: word 0 sits at the MSBs; any index past the program yields a NOP.
  always_comb begin
    fetched_s     = NOP_WORD;
    fetch_valid_s = 1'b0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (index_s == 30'(k)) begin
        fetched_s     = i_datain[32*(NUM_WORDS-k)-1 -: 32];
        fetch_valid_s = 1'b1;
      end else begin
        fetched_s     = fetched_s;
        fetch_valid_s = fetch_valid_s;
      end
    end
  end

  // Next-PC select: redirects take precedence over a fetch stall.
  always_comb begin
    pc_next_s = pc_plus4_s;
    if (branch_taken_e) begin
      pc_next_s = branch_target_e;
    end else if (jump_d) begin
      pc_next_s = jump_target_d;
    end else if (stall_f) begin
      pc_next_s = PC;
    end else begin
      pc_next_s = pc_plus4_s;
    end
  end

  // PC register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      PC <= 32'h0000_0000;
    end else begin
      PC <= pc_next_s;
    end
  end

  // IF/ID register: flush on any redirect, hold on decode stall, else load the fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      InstrD   <= NOP_WORD;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (flush_s) begin
      InstrD   <= NOP_WORD;
      PCPlus4D <= 32'h0000_0000;
      ValidD   <= 1'b0;
    end else if (stall_d) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else begin
      InstrD   <= fetched_s;
      PCPlus4D <= pc_plus4_s;
      ValidD   <= fetch_valid_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, redirects, stalls,
// end-of-program boundary and asynchronous reset.
module tb_fetch_stage;

  localparam int NW = 10;

  logic              clock;
  logic              reset_n;
  logic [32*NW-1:0]  i_datain;
  logic              stall_f;
  logic              stall_d;
  logic              jump_d;
  logic [31:0]       jump_target_d;
  logic              branch_taken_e;
  logic [31:0]       branch_target_e;
  logic [31:0]       PC;
  logic [31:0]       InstrD;
  logic [31:0]       PCPlus4D;
  logic              ValidD;
  logic              end_of_program;

  int checks_r;
  int errors_r;

  fetch_stage #(.NUM_WORDS(NW), .NOP_WORD(32'h0000_0000)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_datain        (i_datain),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .jump_d          (jump_d),
    .jump_target_d   (jump_target_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .PC              (PC),
    .InstrD          (InstrD),
    .PCPlus4D        (PCPlus4D),
    .ValidD          (ValidD),
    .end_of_program  (end_of_program)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_e, input logic [31:0] ins_e,
                            input logic [31:0] p4_e, input logic v_e);
    check_val({tag, ".pc"},    PC,       pc_e);
    check_val({tag, ".instr"}, InstrD,   ins_e);
    check_val({tag, ".pc4"},   PCPlus4D, p4_e);
    check_val({tag, ".valid"}, {31'd0, ValidD}, {31'd0, v_e});
  endtask

  initial begin
    logic [31:0] words [NW];
    checks_r = 0;
    errors_r = 0;
    words[0] = 32'h2001_0001;
    words[1] = 32'h0C00_0007;
    words[2] = 32'h2003_0002;
    words[3] = 32'h0003_3333;
    words[4] = 32'h0004_4444;
    words[5] = 32'h0005_5555;
    words[6] = 32'h0006_6666;
    words[7] = 32'h0007_7777;
    words[8] = 32'h0008_8888;
    words[9] = 32'h0009_9999;
    for (int k = 0; k < NW; k++) i_datain[32*(NW-k)-1 -: 32] = words[k];

    reset_n = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    jump_d = 1'b0;
    jump_target_d = 32'h0;
    branch_taken_e = 1'b0;
    branch_target_e = 32'h0;

    #2;
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check_val("reset.eop", {31'd0, end_of_program}, 32'd0);
    #1 reset_n = 1'b1;

    // Free-running sequential fetch.
    tick(); check_ifid("seq1", 32'h04, 32'h2001_0001, 32'h04, 1'b1);
    tick(); check_ifid("seq2", 32'h08, 32'h0C00_0007, 32'h08, 1'b1);
    tick(); check_ifid("seq3", 32'h0C, 32'h2003_0002, 32'h0C, 1'b1);

    // Branch back to 0x08 so the jump can be issued from PC=0x08.
    branch_taken_e = 1'b1; branch_target_e = 32'h08;
    tick(); check_ifid("br08", 32'h08, 32'h0, 32'h0, 1'b0);
    branch_taken_e = 1'b0;

    jump_d = 1'b1; jump_target_d = 32'h1C;
    tick(); check_ifid("jmp", 32'h1C, 32'h0, 32'h0, 1'b0);
    jump_d = 1'b0;
    tick(); check_ifid("jmp_tgt", 32'h20, 32'h0007_7777, 32'h20, 1'b1);

    // Reach PC=0x10 with word3 in IF/ID, then stall both stages for two cycles.
    branch_taken_e = 1'b1; branch_target_e = 32'h0C;
    tick(); check_ifid("br0c", 32'h0C, 32'h0, 32'h0, 1'b0);
    branch_taken_e = 1'b0;
    tick(); check_ifid("pre_stall", 32'h10, 32'h0003_3333, 32'h10, 1'b1);
    stall_f = 1'b1; stall_d = 1'b1;
    tick(); check_ifid("stall1", 32'h10, 32'h0003_3333, 32'h10, 1'b1);
    tick(); check_ifid("stall2", 32'h10, 32'h0003_3333, 32'h10, 1'b1);
    stall_f = 1'b0; stall_d = 1'b0;
    tick(); check_ifid("unstall", 32'h14, 32'h0004_4444, 32'h14, 1'b1);

    // Branch, jump and stalls together: branch wins and IF/ID flushes.
    branch_taken_e = 1'b1; branch_target_e = 32'h18;
    jump_d = 1'b1; jump_target_d = 32'h04;
    stall_f = 1'b1; stall_d = 1'b1;
    tick(); check_ifid("br_vs_jmp", 32'h18, 32'h0, 32'h0, 1'b0);
    branch_taken_e = 1'b0; jump_d = 1'b0; stall_f = 1'b0; stall_d = 1'b0;

    // Run off the end of the program.
    tick(); check_ifid("run1c", 32'h1C, 32'h0006_6666, 32'h1C, 1'b1);
    tick(); check_ifid("run20", 32'h20, 32'h0007_7777, 32'h20, 1'b1);
    tick(); check_ifid("run24", 32'h24, 32'h0008_8888, 32'h24, 1'b1);
    check_val("eop24", {31'd0, end_of_program}, 32'd0);
    tick(); check_ifid("run28", 32'h28, 32'h0009_9999, 32'h28, 1'b1);
    check_val("eop28", {31'd0, end_of_program}, 32'd1);
    tick(); check_ifid("run2c", 32'h2C, 32'h0, 32'h2C, 1'b0);
    check_val("eop2c", {31'd0, end_of_program}, 32'd1);

    // Asynchronous reset mid-cycle at PC=0x14 with a redirect still asserted.
    branch_taken_e = 1'b1; branch_target_e = 32'h14;
    tick(); check_val("br14.pc", PC, 32'h14);
    branch_taken_e = 1'b0;
    tick(); check_ifid("pre_rst", 32'h18, 32'h0005_5555, 32'h18, 1'b1);
    branch_taken_e = 1'b1; branch_target_e = 32'h14;
    tick(); check_val("br14b.pc", PC, 32'h14);
    jump_d = 1'b1; jump_target_d = 32'h24; stall_f = 1'b1;
    #3 reset_n = 1'b0;
    #1 check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    tick(); check_ifid("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    branch_taken_e = 1'b0; jump_d = 1'b0; stall_f = 1'b0;
    #2 reset_n = 1'b1;
    tick(); check_ifid("post_rst", 32'h04, 32'h2001_0001, 32'h04, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
